// File: rtl/picosoc_memdma.sv
// rtl/picosoc_memdma.sv - FILL/COPY bus initiator for the picosoc SRAM word port
// Single-command engine; memory port outputs are decoded from the current state.
module picosoc_memdma #(
  parameter int ADDR_W = 22,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [31:0]       cmd_pattern,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LEN_W-1:0]  words_done,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_CRD  = 3'd2;
  localparam logic [2:0] S_CWR  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_rem;
  logic [LEN_W-1:0]  r_words;
  logic [31:0]       r_pattern;
  logic              r_aborted;

  logic w_accept;
  logic w_last;

  assign w_accept = cmd_valid && (r_state == S_IDLE);
  // Natural completion takes priority over a coincident abort on the final word.
  assign w_last   = (r_rem == LEN_ONE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_rem     <= '0;
      r_words   <= '0;
      r_pattern <= '0;
      r_aborted <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_src     <= cmd_src;
            r_dst     <= cmd_dst;
            r_rem     <= cmd_len;
            r_pattern <= cmd_pattern;
            r_words   <= '0;
            r_aborted <= 1'b0;
            if (cmd_len == '0)
              r_state <= S_FIN;
            else if (cmd_op)
              r_state <= S_CRD;
            else
              r_state <= S_FILL;
          end
        end
        S_FILL: begin
          r_dst   <= r_dst + ADDR_ONE;
          r_words <= r_words + LEN_ONE;
          r_rem   <= r_rem - LEN_ONE;
          if (w_last) begin
            r_state <= S_FIN;
          end else if (abort) begin
            r_state   <= S_FIN;
            r_aborted <= 1'b1;
          end
        end
        S_CRD: begin
          r_src <= r_src + ADDR_ONE;
          if (abort) begin
            r_state   <= S_FIN;
            r_aborted <= 1'b1;
          end else begin
            r_state <= S_CWR;
          end
        end
        S_CWR: begin
          r_dst   <= r_dst + ADDR_ONE;
          r_words <= r_words + LEN_ONE;
          r_rem   <= r_rem - LEN_ONE;
          if (w_last) begin
            r_state <= S_FIN;
          end else if (abort) begin
            r_state   <= S_FIN;
            r_aborted <= 1'b1;
          end else begin
            r_state <= S_CRD;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // COPY write data comes straight from the registered memory output.
  always_comb begin
    mem_wen   = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      S_FILL: begin
        mem_wen   = 4'hF;
        mem_addr  = r_dst;
        mem_wdata = r_pattern;
      end
      S_CRD: begin
        mem_addr = r_src;
      end
      S_CWR: begin
        mem_wen   = 4'hF;
        mem_addr  = r_dst;
        mem_wdata = mem_rdata;
      end
      default: begin
        mem_wen = 4'h0;
      end
    endcase
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state == S_FILL) || (r_state == S_CRD) || (r_state == S_CWR);
  assign done       = (r_state == S_FIN);
  assign aborted    = (r_state == S_FIN) && r_aborted;
  assign words_done = r_words;

endmodule
